// File: rtl/div_seq.sv
// Iterative restoring radix-2 divider: {remainder, quotient}, WIDTH+2 edges from accept (2 for a zero divisor).
// Result and ready_o are held while start_i stays high; annul_i or dropping start_i returns the sequencer to FREE.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {ST_FREE, ST_BYZERO, ST_ON, ST_END} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               sgn_q, sgn_d;
  logic               neg_dvd_q, neg_dvd_d;
  logic               neg_dvs_q, neg_dvs_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               ready_q, ready_d;

  logic [WIDTH-1:0]   dvd_abs, dvs_abs;
  logic [WIDTH:0]     shifted_hi, trial;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign dvd_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign dvs_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // The bit shifted out of rem_q must take part in the trial subtraction.
  assign shifted_hi = {rem_q, quo_q[WIDTH-1]};
  assign trial      = shifted_hi - {1'b0, dvs_q};

  assign quo_fix = (sgn_q && (neg_dvd_q ^ neg_dvs_q)) ? -quo_q : quo_q;
  assign rem_fix = (sgn_q && neg_dvd_q) ? -rem_q : rem_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    sgn_d     = sgn_q;
    neg_dvd_d = neg_dvd_q;
    neg_dvs_d = neg_dvs_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      ST_FREE: begin
        result_d = '0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          sgn_d     = signed_div_i;
          neg_dvd_d = signed_div_i & opdata1_i[WIDTH-1];
          neg_dvs_d = signed_div_i & opdata2_i[WIDTH-1];
          rem_d     = '0;
          quo_d     = dvd_abs;
          dvs_d     = dvs_abs;
          cnt_d     = '0;
          state_d   = (opdata2_i == '0) ? ST_BYZERO : ST_ON;
        end
      end
      ST_BYZERO: begin
        if (annul_i) begin
          state_d  = ST_FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else begin
          state_d  = ST_END;
          result_d = '0;
          ready_d  = 1'b1;
        end
      end
      ST_ON: begin
        if (annul_i) begin
          state_d  = ST_FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end else if (cnt_q != CW'(WIDTH)) begin
          if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = shifted_hi[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_d = cnt_q + CW'(1);
        end else begin
          state_d  = ST_END;
          result_d = {rem_fix, quo_fix};
          ready_d  = 1'b1;
        end
      end
      ST_END: begin
        if (annul_i || !start_i) begin
          state_d  = ST_FREE;
          cnt_d    = '0;
          result_d = '0;
          ready_d  = 1'b0;
        end
      end
      default: begin
        state_d  = ST_FREE;
        cnt_d    = '0;
        result_d = '0;
        ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FREE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      sgn_q     <= 1'b0;
      neg_dvd_q <= 1'b0;
      neg_dvs_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      sgn_q     <= sgn_d;
      neg_dvd_q <= neg_dvd_d;
      neg_dvs_q <= neg_dvs_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q != ST_FREE);

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: fixed vectors, multi-cycle corner sequences, and random operands vs. an arithmetic model.
module tb_div_seq;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic           signed_div_i;
  logic [W-1:0]   opdata1_i;
  logic [W-1:0]   opdata2_i;
  logic           start_i;
  logic           annul_i;
  logic [2*W-1:0] result_o;
  logic           ready_o;
  logic           busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .busy_o       (busy_o)
  );

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[10];

  // Truncating division in 64-bit arithmetic, so the signed overflow case wraps without trapping.
  function automatic logic [63:0] model(bit sgn, logic [31:0] a, logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return 64'h0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = {32'h0, a};
      sb = {32'h0, b};
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One full request; operands are scrambled after accept, result is held for `hold` extra edges.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int hold, input string name);
    int lat;
    bit seen;
    logic [63:0] res;
    @(negedge clk);
    signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    check({name, "_busy"}, {63'h0, busy_o}, 64'h1);
    @(negedge clk);
    opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = ~sgn;
    seen = ready_o;
    while (!seen && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      seen = ready_o;
    end
    check({name, "_lat"}, 64'(lat), (b == 0) ? 64'd2 : 64'(W + 2));
    res = result_o;
    check({name, "_res"}, res, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, "_hold"}, {ready_o, result_o[62:0]} ^ {1'b0, res[62:0]}, {1'b1, 63'h0});
      check({name, "_hold_msb"}, {63'h0, result_o[63]}, {63'h0, res[63]});
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk); #1;
    check({name, "_drop"}, {ready_o, busy_o, result_o[61:0]}, 64'h0);
    check({name, "_drop_hi"}, {62'h0, result_o[63:62]}, 64'h0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit rs;
    vecs[0] = '{1'b0, 32'h00000007, 32'h00000002, 64'h00000001_00000003};
    vecs[1] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD};
    vecs[2] = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD};
    vecs[3] = '{1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC};
    vecs[4] = '{1'b0, 32'h12345678, 32'h00000000, 64'h0};
    vecs[5] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000};
    vecs[6] = '{1'b0, 32'd100,      32'd7,        64'h00000002_0000000E};
    vecs[7] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 64'h00000000_FFFFFFFF};
    vecs[8] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003};
    vecs[9] = '{1'b1, 32'h80000000, 32'h00000000, 64'h0};

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = '0; opdata2_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", {ready_o, busy_o, result_o[61:0]}, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, 0, $sformatf("vec%0d", i));

    // Result must stay stable while start is held in END.
    run_div(1'b1, 32'hFFFFFFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 5, "hold5");

    // Annul mid-divide at cnt=10.
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk); #1;
    check("annul_on", {ready_o, busy_o, result_o[61:0]}, 64'h0);
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("annul_quiet", {62'h0, ready_o, busy_o}, 64'h0);
    run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 0, "after_annul");

    // Annul in BYZERO.
    @(negedge clk);
    opdata1_i = 32'h12345678; opdata2_i = 32'h0; start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b1;
    @(posedge clk); #1;
    check("annul_byzero", {62'h0, ready_o, busy_o}, 64'h0);
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;

    // Synchronous reset mid-divide at cnt=20.
    @(negedge clk);
    signed_div_i = 1'b1; opdata1_i = 32'hFFFF0000; opdata2_i = 32'd5; start_i = 1'b1;
    repeat (21) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid", {ready_o, busy_o, result_o[61:0]}, 64'h0);
    check("rst_mid_hi", {62'h0, result_o[63:62]}, 64'h0);
    @(negedge clk);
    rst = 1'b0; start_i = 1'b0;
    run_div(1'b0, 32'hFFFFFFFF, 32'h1, 64'h00000000_FFFFFFFF, 0, "after_rst");

    // Random back-to-back requests against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 15));
        1:       rb = 32'hFFFFFFFF - 32'($urandom_range(0, 15));
        default: rb = $urandom;
      endcase
      run_div(rs, ra, rb, model(rs, ra, rb), 0, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
